// File: rtl/bus_write_arbiter.sv
// Round-robin write-bus arbiter for two masters with a burst cap.
// Macro BUS_ARB_FIXED_PRIORITY_EN: M0 wins ties and is never capped.
module bus_write_arbiter #(
  parameter int          MAX_BURST = 4,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       M0_REQ,
  input  logic       M0_WE,
  input  logic [7:0] M0_ADDR,
  input  logic [7:0] M0_DATA,
  output logic       M0_GNT,
  output logic       M0_ACK,
  input  logic       M1_REQ,
  input  logic       M1_WE,
  input  logic [7:0] M1_ADDR,
  input  logic [7:0] M1_DATA,
  output logic       M1_GNT,
  output logic       M1_ACK,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic       BUS_BUSY
);

`ifdef BUS_ARB_FIXED_PRIORITY_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  localparam logic [4:0] CAP = 5'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  logic [4:0] cnt_inc;
  logic [3:0] cnt_sat;
  logic       cap0, cap1;
  state_e     tie_win;

  assign M0_GNT   = (state_q == OWN0);
  assign M1_GNT   = (state_q == OWN1);
  assign BUS_BUSY = M0_GNT | M1_GNT;

  assign cnt_inc = {1'b0, burst_cnt_q} + 5'd1;
  assign cnt_sat = (burst_cnt_q == 4'hF) ? 4'hF : cnt_inc[3:0];
  // M0 is exempt from the cap when fixed priority is enabled
  assign cap0    = !FIXED_PRIO && (cnt_inc >= CAP);
  assign cap1    = (cnt_inc >= CAP);
  assign tie_win = (FIXED_PRIO || last_owner_q) ? OWN0 : OWN1;

  // Bus mux and ACKs: parked unless a master owns the bus
  always_comb begin
    M0_ACK   = 1'b0;
    M1_ACK   = 1'b0;
    BUS_WE   = 1'b0;
    BUS_ADDR = IDLE_ADDR;
    BUS_DATA = 8'h00;
    unique case (state_q)
      OWN0: begin
        M0_ACK   = M0_REQ;
        BUS_WE   = M0_REQ & M0_WE;
        BUS_ADDR = M0_ADDR;
        BUS_DATA = M0_DATA;
      end
      OWN1: begin
        M1_ACK   = M1_REQ;
        BUS_WE   = M1_REQ & M1_WE;
        BUS_ADDR = M1_ADDR;
        BUS_DATA = M1_DATA;
      end
      default: ;
    endcase
  end

  // Next grant, fairness history and burst length
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (M0_REQ && M1_REQ) state_d = tie_win;
        else if (M0_REQ)      state_d = OWN0;
        else if (M1_REQ)      state_d = OWN1;
      end
      OWN0: begin
        if (!M0_REQ) begin
          state_d      = M1_REQ ? OWN1 : IDLE;
          last_owner_d = 1'b0;
          burst_cnt_d  = 4'd0;
        end else if (M1_REQ && cap0) begin
          state_d      = OWN1;
          last_owner_d = 1'b0;
          burst_cnt_d  = 4'd0;
        end else begin
          burst_cnt_d  = cnt_sat;
        end
      end
      OWN1: begin
        if (!M1_REQ) begin
          state_d      = M0_REQ ? OWN0 : IDLE;
          last_owner_d = 1'b1;
          burst_cnt_d  = 4'd0;
        end else if (M0_REQ && cap1) begin
          state_d      = OWN0;
          last_owner_d = 1'b1;
          burst_cnt_d  = 4'd0;
        end else begin
          burst_cnt_d  = cnt_sat;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule
